ioexp_reg_arbiter: RTL
======================

# ioexp_reg_arbiter

Shared register-bank controller for the CPLD's PCA9555-style I/O expander. Owns the eight expander registers (input, output, polarity, config for two 8-bit ports) and arbitrates access between two requesters: the I2C slave engine (port A) and local board-management logic (port B). It also samples the physical port inputs on a fixed period and drives an open-drain-style active-low interrupt when configured inputs change.

## Interface
Parameters:
- SAMPLE_DIV, 50: clk cycles between input samples (1 µs at 50 MHz); legal range 2..255.

Ports:
- clk  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- a_req  in  1  requester A access request; held high until a_ack
- a_we  in  1  A write enable (1 = write, 0 = read); stable while a_req is high
- a_addr  in  3  A register index 0..7
- a_wdata  in  8  A write data
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  8  A read data; valid while a_ack is high, held afterwards
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the A signals, for requester B
- port0_in, port1_in  in  8 each  synchronized pad inputs
- port0_out, port1_out  out  8 each  output registers (reg 2/3)
- port0_cfg, port1_cfg  out  8 each  config registers (reg 6/7; 1 = input)
- int_n  out  1  interrupt, active low

## Operation
- Register map:
  - 0/1: input port, read-only; returns sample XOR polarity. Writes are acked and discarded.
  - 2/3: output.
  - 4/5: polarity inversion.
  - 6/7: config.
- Reset values: reg2/3 = FF, reg4/5 = 00, reg6/7 = FF, input samples = 00, snapshots = 00. All outputs go to their reset values: a_ack = b_ack = 0, a_rdata = b_rdata = 00, int_n = 1.
- FSM states:
  - IDLE: if any req is high, latch the winner's we/addr/wdata and go to ACCESS.
  - ACCESS: commit the write, or capture the read data; go to ACK.
  - ACK: pulse the winner's ack and drive its rdata; go to IDLE.
- Arbitration is round-robin via a last-served flag (reset value = B, so A wins the first tie).
  - Only one requester is serviced per transaction.
  - The loser keeps its req high and is served next.
- A requester must drop req in the cycle after its ack. If req is still high in IDLE, it is a new request.
- Input sampler:
  - A counter runs 0..SAMPLE_DIV-1; on wrap it captures port0_in/port1_in into the sample registers.
- Interrupt:
  - Each port has a snapshot register, updated with the current sample whenever reg 0/1 of that port is read.
  - int_n = 0 when any bit with cfg = 1 differs between sample and snapshot.
  - int_n returns to 1 when the inputs return to the snapshot, or the port is read.
  - Bits with cfg = 0 never interrupt.
- Simultaneous sample update and read of the same port in one cycle:
  - The read returns the pre-update sample.
  - The snapshot takes that same pre-update value, so the new change raises int_n on the next cycle.
- Writes to cfg take effect on the int_n mask the cycle after commit.

## Timing
- Request seen high at edge N (in IDLE): ACCESS at N+1, ack high in cycle N+2, IDLE at N+3.
- Back-to-back service of A then B: B's ack arrives 3 cycles after A's.
- Write data is visible on port*_out/port*_cfg the cycle after ACCESS, i.e. coincident with ack.
- int_n is registered: one cycle after a sample/snapshot mismatch appears.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with ack low.
  - A write is committed only if the ACCESS edge completed before reset.
  - Registers revert to reset values anyway.
- Sample counter restarts at 0 on reset; the first sample is taken SAMPLE_DIV cycles after reset release.

## Structure
- Package ioexp_pkg holds:
  - Register index constants REG_IN0..REG_CFG1.
  - Reset values (OUT_RST = FF, POL_RST = 00, CFG_RST = FF).
  - FSM state enum {IDLE, ACCESS, ACK}.
- Sub-module ioexp_input_sampler contains the divider counter, sample registers, snapshots and int_n generation. Its inputs are read-strobe and port select from the arbiter.
- Arbiter FSM and register bank live in the top module.

## Test plan
- Reset, then read all 8 regs via A → rdata 00,00,FF,FF,00,00,FF,FF; int_n = 1.
- A and B request at the same edge (A write reg2 = 5A, B read reg2) → A acked first, B acked 3 cycles later with rdata 5A; port0_out = 5A.
- Write reg4 = 0F, port0_in = 33, wait one sample period, read reg0 → 3C.
- port1_in changes 00→80 with cfg1 = FF → int_n low ≤ SAMPLE_DIV+2 cycles later; read reg1 → rdata 80, int_n high next cycle. Repeat with cfg1 = 7F → int_n stays high.
- Write reg0 = AA via B → ack given, subsequent reg0 read still reflects the sample.
- Assert RST while in ACCESS for a write of reg3 = 00 → after release, reg3 = FF and no ack pulse.

Source files
------------

// File: rtl/ioexp_pkg.sv
// Shared constants and types for the I/O expander register arbiter.
package ioexp_pkg;

  localparam logic [2:0] REG_IN0  = 3'd0;
  localparam logic [2:0] REG_IN1  = 3'd1;
  localparam logic [2:0] REG_OUT0 = 3'd2;
  localparam logic [2:0] REG_OUT1 = 3'd3;
  localparam logic [2:0] REG_POL0 = 3'd4;
  localparam logic [2:0] REG_POL1 = 3'd5;
  localparam logic [2:0] REG_CFG0 = 3'd6;
  localparam logic [2:0] REG_CFG1 = 3'd7;

  localparam logic [7:0] OUT_RST = 8'hFF;
  localparam logic [7:0] POL_RST = 8'h00;
  localparam logic [7:0] CFG_RST = 8'hFF;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  // Registers 0/1 mirror the sampled pads and cannot be written.
  function automatic logic is_input_reg(input logic [2:0] addr);
    return addr[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/ioexp_reg_arbiter_if.sv
// One requester's register-access handshake; master = requester, slave = arbiter.
interface ioexp_reg_arbiter_if;
  logic       req;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ioexp_input_sampler.sv
// Periodic pad sampler with per-port read snapshots and the change interrupt.
module ioexp_input_sampler #(
  parameter int SAMPLE_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port0_in,
  input  logic [7:0] port1_in,
  input  logic [7:0] cfg0,
  input  logic [7:0] cfg1,
  input  logic       rd_strobe,
  input  logic       rd_port,
  output logic [7:0] sample0,
  output logic [7:0] sample1,
  output logic       int_n
);

  logic [7:0] cnt;
  logic [7:0] snap0;
  logic [7:0] snap1;
  logic [7:0] pending;
  logic       wrap;

  assign wrap    = (cnt == 8'(SAMPLE_DIV - 1));
  assign pending = ((sample0 ^ snap0) & cfg0) | ((sample1 ^ snap1) & cfg1);

  // Snapshots take the pre-update sample when a read coincides with a sample wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 8'd0;
      sample0 <= 8'h00;
      sample1 <= 8'h00;
      snap0   <= 8'h00;
      snap1   <= 8'h00;
      int_n   <= 1'b1;
    end else begin
      cnt <= wrap ? 8'd0 : cnt + 8'd1;
      if (wrap) begin
        sample0 <= port0_in;
        sample1 <= port1_in;
      end
      if (rd_strobe && !rd_port) snap0 <= sample0;
      if (rd_strobe &&  rd_port) snap1 <= sample1;
      int_n <= ~(|pending);
    end
  end

endmodule

// File: rtl/ioexp_reg_arbiter.sv
// Round-robin arbiter and register bank for the PCA9555-style expander.
//   state  | meaning
//   IDLE   | wait for a request, latch the winner's command
//   ACCESS | commit write or capture read data
//   ACK    | pulse the winner's ack
module ioexp_reg_arbiter
  import ioexp_pkg::*;
#(
  parameter int SAMPLE_DIV = 50
) (
  input  logic                  clk,
  input  logic                  RST,
  ioexp_reg_arbiter_if.slave    a,
  ioexp_reg_arbiter_if.slave    b,
  input  logic [7:0]            port0_in,
  input  logic [7:0]            port1_in,
  output logic [7:0]            port0_out,
  output logic [7:0]            port1_out,
  output logic [7:0]            port0_cfg,
  output logic [7:0]            port1_cfg,
  output logic                  int_n
);

  state_t          state_q, state_d;
  logic            start, grant_b;
  logic            sel_q, we_q, last_b_q;
  logic [2:0]      addr_q;
  logic [7:0]      wdata_q, rd_val;
  logic [7:0]      a_rdata_q, b_rdata_q;
  logic [1:0][7:0] out_q, pol_q, cfg_q;
  logic [7:0]      sample0, sample1;
  logic            access, rd_strobe;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        if (a.req || b.req) begin
          start   = 1'b1;
          grant_b = b.req && (!a.req || !last_b_q);
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign access    = (state_q == ACCESS);
  assign rd_strobe = access && !we_q && is_input_reg(addr_q);

  always_comb begin
    rd_val = 8'h00;
    case (addr_q)
      REG_IN0:  rd_val = sample0 ^ pol_q[0];
      REG_IN1:  rd_val = sample1 ^ pol_q[1];
      REG_OUT0: rd_val = out_q[0];
      REG_OUT1: rd_val = out_q[1];
      REG_POL0: rd_val = pol_q[0];
      REG_POL1: rd_val = pol_q[1];
      REG_CFG0: rd_val = cfg_q[0];
      REG_CFG1: rd_val = cfg_q[1];
      default:  rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 3'd0;
      wdata_q   <= 8'h00;
      last_b_q  <= 1'b1;
      a_rdata_q <= 8'h00;
      b_rdata_q <= 8'h00;
      out_q     <= {OUT_RST, OUT_RST};
      pol_q     <= {POL_RST, POL_RST};
      cfg_q     <= {CFG_RST, CFG_RST};
    end else begin
      if (start) begin
        sel_q    <= grant_b;
        last_b_q <= grant_b;
        we_q     <= grant_b ? b.we    : a.we;
        addr_q   <= grant_b ? b.addr  : a.addr;
        wdata_q  <= grant_b ? b.wdata : a.wdata;
      end
      if (access && we_q) begin
        case (addr_q)
          REG_OUT0: out_q[0] <= wdata_q;
          REG_OUT1: out_q[1] <= wdata_q;
          REG_POL0: pol_q[0] <= wdata_q;
          REG_POL1: pol_q[1] <= wdata_q;
          REG_CFG0: cfg_q[0] <= wdata_q;
          REG_CFG1: cfg_q[1] <= wdata_q;
          default: ;
        endcase
      end
      if (access && !we_q) begin
        if (sel_q) b_rdata_q <= rd_val;
        else       a_rdata_q <= rd_val;
      end
    end
  end

  assign a.ack   = (state_q == ACK) && !sel_q;
  assign b.ack   = (state_q == ACK) &&  sel_q;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;

  assign port0_out = out_q[0];
  assign port1_out = out_q[1];
  assign port0_cfg = cfg_q[0];
  assign port1_cfg = cfg_q[1];

  ioexp_input_sampler #(.SAMPLE_DIV(SAMPLE_DIV)) u_sampler (
    .clk       (clk),
    .rst_n     (RST),
    .port0_in  (port0_in),
    .port1_in  (port1_in),
    .cfg0      (cfg_q[0]),
    .cfg1      (cfg_q[1]),
    .rd_strobe (rd_strobe),
    .rd_port   (addr_q[0]),
    .sample0   (sample0),
    .sample1   (sample1),
    .int_n     (int_n)
  );

endmodule
